// File: rtl/pixel_lut_if.sv
// Pixel LUT bus: lookup request/response, host table write port and init control.
//   master : upstream/host side (drives requests, writes, init_req)
//   slave  : LUT side (drives out_valid, out_data, busy)
interface pixel_lut_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                         in_valid;
  logic [CHANNELS*ADDR_W-1:0]   in_addr;
  logic [CHANNELS-1:0]          bypass;
  logic                         out_valid;
  logic [CHANNELS*DATA_W-1:0]   out_data;
  logic                         wr_en;
  logic [CH_W-1:0]              wr_chan;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic                         init_req;
  logic                         busy;

  modport master (
    output in_valid, in_addr, bypass, wr_en, wr_chan, wr_addr, wr_data, init_req,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_addr, bypass, wr_en, wr_chan, wr_addr, wr_data, init_req,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/pixel_lut_multi.sv
// Runtime-loadable multi-channel pixel lookup table.
// One lookup per clock across CHANNELS independent tables, host write port,
// identity self-initialisation (INIT) after reset or on init_req, per-channel bypass.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pixel_lut_if.slave (in_valid/in_addr/bypass -> out_valid/out_data,
//                wr_en/wr_chan/wr_addr/wr_data host writes, init_req -> busy)
module pixel_lut_multi #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LATENCY  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pixel_lut_if.slave     bus
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned OUT_W = CHANNELS * DATA_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  cnt, cnt_d;
  logic               busy_q;
  logic               init_we_c;
  logic               host_we_c;
  logic               rd_en_c;
  logic [OUT_W-1:0]   lane_c;
  logic               v1_q;
  logic [OUT_W-1:0]   d1_q;

  // Zero-extend or truncate an address to table entry width.
  function automatic logic [DATA_W-1:0] resize_addr(input logic [ADDR_W-1:0] x);
    return DATA_W'(x);
  endfunction

  // State register; busy tracks the state being entered so it falls right after the last INIT write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      busy_q <= (state_d == ST_INIT);
    end
  end

  // Next state and per-cycle enables; requests, writes and init_req are ignored in INIT.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    init_we_c = 1'b0;
    host_we_c = 1'b0;
    rd_en_c   = 1'b0;
    case (state)
      ST_INIT: begin
        init_we_c = 1'b1;
        cnt_d     = ADDR_W'(cnt + 1'b1);
        if (cnt == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        host_we_c = bus.wr_en;
        rd_en_c   = bus.in_valid;
        if (bus.init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-channel table; the read is captured in d1_q, so a same-cycle write is seen next access.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DATA_W-1:0] tbl [DEPTH];
    logic [ADDR_W-1:0] addr_c;
    logic              sel_c;

    assign addr_c = bus.in_addr[g*ADDR_W +: ADDR_W];
    // Out-of-range wr_chan matches no channel, so such writes are dropped.
    assign sel_c  = host_we_c && (bus.wr_chan == CH_W'(g));

    always_ff @(posedge clk) begin
      if (init_we_c)  tbl[cnt]         <= resize_addr(cnt);
      else if (sel_c) tbl[bus.wr_addr] <= bus.wr_data;
    end

    assign lane_c[g*DATA_W +: DATA_W] = bus.bypass[g] ? resize_addr(addr_c) : tbl[addr_c];
  end

  // First result stage (registered read); data holds when no request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_en_c;
      if (rd_en_c) d1_q <= lane_c;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic             v2_q;
    logic [OUT_W-1:0] d2_q;

    // Extra output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign bus.out_valid = v2_q;
    assign bus.out_data  = d2_q;
  end else begin : g_lat1
    assign bus.out_valid = v1_q;
    assign bus.out_data  = d1_q;
  end

  assign bus.busy = busy_q;
endmodule

// File: tb/tb_pixel_lut_multi.sv
// Testbench for pixel_lut_multi: LATENCY=1 and LATENCY=2 instances share one
// stimulus stream and are compared every cycle against a table-level reference model,
// plus directed checks with fixed expected values.
module tb_pixel_lut_multi;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_addr;
  logic [2:0]  bypass;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        init_req;

  pixel_lut_if #(.CHANNELS(3), .ADDR_W(8), .DATA_W(8)) b1 ();
  pixel_lut_if #(.CHANNELS(3), .ADDR_W(8), .DATA_W(8)) b2 ();

  assign b1.in_valid = in_valid;
  assign b1.in_addr  = in_addr;
  assign b1.bypass   = bypass;
  assign b1.wr_en    = wr_en;
  assign b1.wr_chan  = wr_chan;
  assign b1.wr_addr  = wr_addr;
  assign b1.wr_data  = wr_data;
  assign b1.init_req = init_req;
  assign b2.in_valid = in_valid;
  assign b2.in_addr  = in_addr;
  assign b2.bypass   = bypass;
  assign b2.wr_en    = wr_en;
  assign b2.wr_chan  = wr_chan;
  assign b2.wr_addr  = wr_addr;
  assign b2.wr_data  = wr_data;
  assign b2.init_req = init_req;

  pixel_lut_multi #(.CHANNELS(3), .ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  pixel_lut_multi #(.CHANNELS(3), .ADDR_W(8), .DATA_W(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: table contents, init progress, and expected outputs per latency.
  bit [7:0]  mtab [3][256];
  bit        m_busy;
  int        m_cnt;
  bit        e1v, e2v, pv;
  bit [23:0] e1d, e2d, pd;

  function automatic bit [23:0] ref_lookup(input bit [23:0] a, input bit [2:0] byp);
    bit [23:0] r;
    bit [7:0]  ab;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ab = a[c*8 +: 8];
      r[c*8 +: 8] = byp[c] ? ab : mtab[c][ab];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    e1v = 1'b0; e2v = 1'b0; pv = 1'b0;
    e1d = '0;   e2d = '0;   pd = '0;
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit        rv;
    bit [23:0] rd;
    rv = 1'b0;
    rd = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      for (int c = 0; c < 3; c++) mtab[c][m_cnt] = 8'(m_cnt);
      if (m_cnt == 255) m_busy = 1'b0;
      else m_cnt++;
    end else begin
      if (in_valid) begin
        rv = 1'b1;
        rd = ref_lookup(in_addr, bypass);
      end
      if (wr_en && wr_chan < 2'd3) mtab[wr_chan][wr_addr] = wr_data;
      if (init_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    e2v = pv;
    if (pv) e2d = pd;
    pv = rv;
    if (rv) pd = rd;
    e1v = rv;
    if (rv) e1d = rd;
  endtask

  task automatic check_outputs();
    check("busy_l1",  32'(b1.busy),      32'(m_busy));
    check("busy_l2",  32'(b2.busy),      32'(m_busy));
    check("valid_l1", 32'(b1.out_valid), 32'(e1v));
    check("data_l1",  32'(b1.out_data),  32'(e1d));
    check("valid_l2", 32'(b2.out_valid), 32'(e2v));
    check("data_l2",  32'(b2.out_data),  32'(e2d));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Counts cycles with busy=1 from the current one onward, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (b1.busy && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic lookup_chk(input string tag, input logic [23:0] addr,
                            input logic [2:0] byp, input logic [23:0] exp);
    in_valid = 1'b1;
    in_addr  = addr;
    bypass   = byp;
    tick();
    in_valid = 1'b0;
    wr_en    = 1'b0;
    bypass   = '0;
    check({tag, "_v1"}, 32'(b1.out_valid), 32'd1);
    check({tag, "_d1"}, 32'(b1.out_data),  32'(exp));
    tick();
    check({tag, "_v2"}, 32'(b2.out_valid), 32'd1);
    check({tag, "_d2"}, 32'(b2.out_data),  32'(exp));
  endtask

  initial begin
    int n;
    in_valid = 1'b0; in_addr = '0; bypass = '0; wr_en = 1'b0;
    wr_chan = '0; wr_addr = '0; wr_data = '0; init_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_busy",  32'(b1.busy),      32'd1);
    check("rst_valid", 32'(b2.out_valid), 32'd0);

    // Power-up INIT length, then identity lookup.
    rst_n = 1'b1;
    wait_init(n);
    check("init_len_por", 32'(n), 32'd256);
    lookup_chk("t1", 24'hAAAAAA, 3'b000, 24'hAAAAAA);

    // Host write, then a dropped write to a nonexistent channel.
    wr_en = 1'b1; wr_chan = 2'd1; wr_addr = 8'hAA; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    lookup_chk("t2", 24'hAAAAAA, 3'b000, 24'hAA55AA);
    wr_en = 1'b1; wr_chan = 2'd3; wr_addr = 8'hAA; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    lookup_chk("t2_drop", 24'hAAAAAA, 3'b000, 24'hAA55AA);

    // Same-cycle read and write returns old data.
    wr_en = 1'b1; wr_chan = 2'd0; wr_addr = 8'h10; wr_data = 8'hF0;
    lookup_chk("t3_rbw", 24'h101010, 3'b000, 24'h101010);
    lookup_chk("t3_new", 24'h101010, 3'b000, 24'h1010F0);

    // Bypass on ch2 hides the loaded entry.
    wr_en = 1'b1; wr_chan = 2'd2; wr_addr = 8'h20; wr_data = 8'h00;
    tick();
    wr_en = 1'b0;
    lookup_chk("t4_byp",   24'h202020, 3'b100, 24'h202020);
    lookup_chk("t4_nobyp", 24'h202020, 3'b000, 24'h002020);

    // init_req during continuous lookups.
    in_valid = 1'b1; in_addr = 24'hAAAAAA;
    repeat (3) tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    check("t5_old_l1", 32'(b1.out_data), 32'h00AA55AA);
    wait_init(n);
    check("init_len_req", 32'(n), 32'd256);
    check("t5_old_l2", 32'(b2.out_data), 32'h00AA55AA);
    in_valid = 1'b0;
    tick();
    lookup_chk("t5_id_a", 24'hAAAAAA, 3'b000, 24'hAAAAAA);
    lookup_chk("t5_id_b", 24'h101010, 3'b000, 24'h101010);
    lookup_chk("t5_id_c", 24'h202020, 3'b000, 24'h202020);

    // Random traffic; small address pool to provoke read/write collisions.
    for (int i = 0; i < 4000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int c = 0; c < 3; c++)
        in_addr[c*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      bypass   = 3'($urandom);
      wr_en    = 1'($urandom_range(0, 1));
      wr_chan  = 2'($urandom_range(0, 3));
      wr_addr  = 8'($urandom_range(0, 15));
      wr_data  = 8'($urandom);
      init_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_valid = 1'b0; wr_en = 1'b0; init_req = 1'b0; bypass = '0;
    repeat (3) tick();
    wait_init(n);

    // Reset with a result on the output: clears without a clock edge.
    lookup_chk("pre_rst", 24'h000000, 3'b111, 24'h000000);
    in_valid = 1'b1; in_addr = 24'h123456; bypass = 3'b111;
    tick();
    in_valid = 1'b0; bypass = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_v1", 32'(b1.out_valid), 32'd0);
    check("rst_async_d1", 32'(b1.out_data),  32'd0);
    check("rst_async_b",  32'(b1.busy),      32'd1);
    tick();
    rst_n = 1'b1;
    wait_init(n);
    check("init_len_rst1", 32'(n), 32'd256);

    // Reset at init count 100 restarts INIT from zero.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_busy_l1",  32'(b1.busy),      32'd1);
    check("t6_busy_l2",  32'(b2.busy),      32'd1);
    check("t6_valid_l1", 32'(b1.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_init(n);
    check("init_len_rst2", 32'(n), 32'd256);
    lookup_chk("t6_id_00", 24'h000000, 3'b000, 24'h000000);
    lookup_chk("t6_id_ff", 24'hFFFFFF, 3'b000, 24'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
